vector_alu_sequencer: RTL and testbench
=======================================

Name: vector_alu_sequencer

Overview:
- Multi-cycle controller that drives one combinational vector_alu through a fixed cipher-round microprogram: initial key XOR, then per round SUBBYTES, ROT, XOR round key.
- Decryption mode runs the exact inverse: XOR, inverse ROT, INV_SUBBYTES.
- Sits between the core's vector issue logic and the shared vector_alu. It owns the ALU operand/control lines for the whole operation and fetches round keys from the vector key register file.

Parameters:
- WIDTH, 128, datapath width in bits; must match the vector_alu WIDTH.
- ROUNDS, 10, number of rounds; legal range 1..15.
- ROT_AMT, 32, left-rotate amount per encrypt round; legal range 1..WIDTH-1.
- KIDX_W, 4, key index width; must satisfy 2^KIDX_W > ROUNDS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- mode  in  1  0=encrypt, 1=decrypt; sampled with start
- data_in  in  WIDTH  input block; sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- data_out  out  WIDTH  result block
- key_idx  out  KIDX_W  round-key read index
- key_data  in  WIDTH  round key; combinational read of key_idx in the same cycle
- alu_op1  out  WIDTH  to vector_alu op1
- alu_op2  out  WIDTH  to vector_alu op2
- alu_control  out  4  to vector_alu alu_control
- alu_result  in  WIDTH  from vector_alu result

Behaviour:
- ALU opcodes: XOR=4'b0000, ROT=4'b0001, SUBBYTES=4'b1000, INV_SUBBYTES=4'b1001.
  - ROT rotates op1 left by op2[6:0].
  - For ROT, alu_op2 = zero-extended amount.
  - For SUB/INV_SUB, alu_op2 = 0.
  - For XOR, alu_op2 = key_data.
- Registers:
  - state register S (WIDTH)
  - mode_q
  - round counter rnd (KIDX_W)
  - FSM: IDLE, KXOR, SUB, ROT
- alu_op1 = S always.
- One ALU op per cycle. On each edge in a non-IDLE state, S <= alu_result.
- Encrypt sequence:
  - KXOR(k0)
  - then for r=1..ROUNDS: SUB, ROT(ROT_AMT), KXOR(kr)
- Decrypt sequence:
  - KXOR(k_ROUNDS)
  - then for r=ROUNDS-1 down to 0: ROT(WIDTH-ROT_AMT), INV_SUB, KXOR(kr)
  - In decrypt, the SUB state issues INV_SUBBYTES and follows ROT.
- FSM transitions:
  - Encrypt: IDLE -start-> KXOR -> SUB -> ROT -> KXOR ...
  - Decrypt: IDLE -start-> KXOR -> ROT -> SUB -> KXOR ...
  - Exit from KXOR to IDLE when the final key (k_ROUNDS for encrypt, k0 for decrypt) has been applied.
- key_idx:
  - equals rnd in KXOR
  - equals 0 in all other states, including IDLE
  - rnd starts at 0 for encrypt, ROUNDS for decrypt; increments/decrements after each non-final KXOR.
- Latency:
  - start accepted at edge E0 (S <= data_in, busy <= 1).
  - Exactly 1+3*ROUNDS op cycles follow (31 for default).
  - At edge E0+1+3*ROUNDS: busy <= 0, done <= 1 for one cycle, data_out <= final S.
- data_out holds its value until the next completion.
- A start in the done cycle is accepted: back-to-back operation with no bubble.
- start while busy=1: ignored, with no effect on S, mode, or the sequence.
- mode and data_in changes while busy: ignored.
- IDLE outputs: alu_control=XOR, alu_op2=0, key_idx=0.
- Reset (asynchronous, any time, including mid-operation):
  - FSM=IDLE, S=0, data_out=0, rnd=0, mode_q=0, busy=0, done=0.
  - The operation in progress is abandoned and no done is issued.
  - The first start after reset release behaves normally.

Test Plan:
- ROUNDS=1, encrypt, k0=k1=0, data_in=0 -> alu_control sequence 0000,1000,0001,0000. done 4 cycles after the start edge. data_out=128'h63636363...63.
- ROUNDS=2, encrypt, observe per-cycle outputs -> alu_control=0000,1000,0001,0000,1000,0001,0000. key_idx=0,0,0,1,0,0,2. ROT cycles have alu_op2=32.
- Default params, keys k[i]=128'h000102030405060708090A0B0C0D0E0F ^ i:
  - encrypt 128'h00112233445566778899AABBCCDDEEFF, then decrypt the result.
  - Decrypt returns the original plaintext.
  - Each operation completes in exactly 31 cycles.
  - Results match a software model.
- Pulse start with data_in=all-ones at cycle 5 of a running operation -> ignored; data_out equals the single-operation reference value; exactly one done pulse.
- Assert rst at cycle 12 of an encrypt -> busy, done, data_out go to 0 immediately without waiting for an edge. No done afterwards. A fresh encrypt after release gives the correct result.
- Assert start in the done cycle with a new block -> accepted; the second done arrives 31 cycles later; the first data_out stays stable until then.

Source files
------------

// File: rtl/vector_alu_sequencer.sv
// Microprogram controller driving an external combinational vector_alu through
// key-XOR / SUBBYTES / ROT cipher rounds (encrypt) or their exact inverse (decrypt).
module vector_alu_sequencer #(
    parameter int WIDTH   = 128,
    parameter int ROUNDS  = 10,
    parameter int ROT_AMT = 32,
    parameter int KIDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [WIDTH-1:0]  data_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  data_out,
    output logic [KIDX_W-1:0] key_idx,
    input  logic [WIDTH-1:0]  key_data,
    output logic [WIDTH-1:0]  alu_op1,
    output logic [WIDTH-1:0]  alu_op2,
    output logic [3:0]        alu_control,
    input  logic [WIDTH-1:0]  alu_result
);

    localparam logic [3:0] OP_XOR     = 4'b0000;
    localparam logic [3:0] OP_ROT     = 4'b0001;
    localparam logic [3:0] OP_SUB     = 4'b1000;
    localparam logic [3:0] OP_INV_SUB = 4'b1001;

    localparam logic [KIDX_W-1:0] LAST_RND = KIDX_W'(ROUNDS);
    localparam logic [WIDTH-1:0]  ENC_ROT  = WIDTH'(ROT_AMT);
    localparam logic [WIDTH-1:0]  DEC_ROT  = WIDTH'(WIDTH - ROT_AMT);

    typedef enum logic [1:0] {
        IDLE,
        KXOR,
        SUB,
        ROT
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  s_q;
    logic              mode_q;
    logic [KIDX_W-1:0] rnd_q;
    logic              last_key;

    // Encrypt walks keys upward and ends on k_ROUNDS; decrypt walks down to k0.
    assign last_key = mode_q ? (rnd_q == '0) : (rnd_q == LAST_RND);
    assign alu_op1  = s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_control = OP_XOR;
        alu_op2     = '0;
        key_idx     = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = KXOR;
                end
            end
            KXOR: begin
                alu_op2 = key_data;
                key_idx = rnd_q;
                if (last_key) begin
                    state_d = IDLE;
                end else begin
                    state_d = mode_q ? ROT : SUB;
                end
            end
            SUB: begin
                alu_control = mode_q ? OP_INV_SUB : OP_SUB;
                state_d     = mode_q ? KXOR : ROT;
            end
            ROT: begin
                alu_control = OP_ROT;
                alu_op2     = mode_q ? DEC_ROT : ENC_ROT;
                state_d     = mode_q ? SUB : KXOR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q      <= '0;
            mode_q   <= 1'b0;
            rnd_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            if (state_q == IDLE) begin
                if (start) begin
                    s_q    <= data_in;
                    mode_q <= mode;
                    rnd_q  <= mode ? LAST_RND : '0;
                    busy   <= 1'b1;
                end
            end else begin
                s_q <= alu_result;
                if (state_q == KXOR) begin
                    if (last_key) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        data_out <= alu_result;
                    end else begin
                        rnd_q <= mode_q ? (rnd_q - 1'b1) : (rnd_q + 1'b1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Scoreboard bench for vector_alu_sequencer with a behavioural vector_alu model
// (AES S-box computed from GF(2^8) inversion) and three parameterisations.
module tb_vector_alu_sequencer;

    localparam logic [127:0] KBASE = 128'h000102030405060708090A0B0C0D0E0F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [127:0] sb_q[$];
    logic [127:0] keys [16];

    // ---------------- ALU reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ rol8(v, 1) ^ rol8(v, 2) ^ rol8(v, 3) ^ rol8(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rol8(s, 1) ^ rol8(s, 3) ^ rol8(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x, input bit inv);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[i*8 +: 8] = inv ? inv_sbox(x[i*8 +: 8]) : sbox(x[i*8 +: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
        return (x << n) | (x >> (128 - n));
    endfunction

    function automatic logic [127:0] alu_f(input logic [127:0] a, input logic [127:0] b,
                                           input logic [3:0] c);
        case (c)
            4'b0000: return a ^ b;
            4'b0001: return rotl(a, int'(b[6:0]));
            4'b1000: return sub_bytes(a, 1'b0);
            4'b1001: return sub_bytes(a, 1'b1);
            default: return '0;
        endcase
    endfunction

    function automatic logic [127:0] enc_ref(input logic [127:0] p);
        logic [127:0] x;
        x = p ^ keys[0];
        for (int r = 1; r <= 10; r++) begin
            x = rotl(sub_bytes(x, 1'b0), 32) ^ keys[r];
        end
        return x;
    endfunction

    // ---------------- DUT: default parameters ----------------
    logic         start, mode;
    logic [127:0] data_in, data_out, key_data, alu_op1, alu_op2, alu_result;
    logic         busy, done;
    logic [3:0]   key_idx, alu_control;

    assign key_data   = keys[key_idx];
    assign alu_result = alu_f(alu_op1, alu_op2, alu_control);

    vector_alu_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .data_in(data_in),
        .busy(busy), .done(done), .data_out(data_out), .key_idx(key_idx),
        .key_data(key_data), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_control(alu_control), .alu_result(alu_result)
    );

    // ---------------- DUT: ROUNDS=1, zero keys ----------------
    logic         r1_start, r1_busy, r1_done;
    logic [127:0] r1_data_out, r1_op1, r1_op2, r1_result;
    logic [3:0]   r1_key_idx, r1_ctrl;

    assign r1_result = alu_f(r1_op1, r1_op2, r1_ctrl);

    vector_alu_sequencer #(.ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst), .start(r1_start), .mode(1'b0), .data_in(128'd0),
        .busy(r1_busy), .done(r1_done), .data_out(r1_data_out), .key_idx(r1_key_idx),
        .key_data(128'd0), .alu_op1(r1_op1), .alu_op2(r1_op2),
        .alu_control(r1_ctrl), .alu_result(r1_result)
    );

    // ---------------- DUT: ROUNDS=2 ----------------
    logic         r2_start, r2_busy, r2_done;
    logic [127:0] r2_data_in, r2_data_out, r2_key_data, r2_op1, r2_op2, r2_result;
    logic [3:0]   r2_key_idx, r2_ctrl;

    assign r2_key_data = keys[r2_key_idx];
    assign r2_result   = alu_f(r2_op1, r2_op2, r2_ctrl);

    vector_alu_sequencer #(.ROUNDS(2)) u_r2 (
        .clk(clk), .rst(rst), .start(r2_start), .mode(1'b0), .data_in(r2_data_in),
        .busy(r2_busy), .done(r2_done), .data_out(r2_data_out), .key_idx(r2_key_idx),
        .key_data(r2_key_data), .alu_op1(r2_op1), .alu_op2(r2_op2),
        .alu_control(r2_ctrl), .alu_result(r2_result)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic start_op(input logic m, input logic [127:0] d);
        @(negedge clk);
        start   = 1'b1;
        mode    = m;
        data_in = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the accept edge until done is seen, bounded.
    task automatic wait_done(inout int n, output bit timed_out);
        timed_out = 1'b0;
        while (!done) begin
            if (n >= 200) begin
                timed_out = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({busy, done, key_idx, alu_control} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/key_idx/alu_control got %b want 0",
                     {busy, done, key_idx, alu_control});
        end
        checks++;
        if ({data_out, alu_op1, alu_op2} !== '0) begin
            errors++;
            $display("FAIL reset_data: data_out=%h op1=%h op2=%h want all 0",
                     data_out, alu_op1, alu_op2);
        end
        checks++;
        if ({r1_busy, r1_done, r2_busy, r2_done} !== 4'd0) begin
            errors++;
            $display("FAIL reset_small: r1/r2 busy,done got %b want 0000",
                     {r1_busy, r1_done, r2_busy, r2_done});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rounds1();
        logic [3:0] exp_ctrl [4] = '{4'b0000, 4'b1000, 4'b0001, 4'b0000};
        bit seq_ok = 1'b1;
        @(negedge clk);
        r1_start = 1'b1;
        @(negedge clk);
        r1_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (r1_ctrl !== exp_ctrl[i] || r1_done !== 1'b0 || r1_busy !== 1'b1) begin
                seq_ok = 1'b0;
                $display("FAIL r1_seq: cycle %0d ctrl=%b done=%b busy=%b want ctrl=%b done=0 busy=1",
                         i, r1_ctrl, r1_done, r1_busy, exp_ctrl[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (!seq_ok) errors++;
        checks++;
        if ({r1_done, r1_busy} !== 2'b10) begin
            errors++;
            $display("FAIL r1_done: done,busy got %b want 10 four cycles after start", {r1_done, r1_busy});
        end
        checks++;
        if (r1_data_out !== {16{8'h63}}) begin
            errors++;
            $display("FAIL r1_data: got %h want %h", r1_data_out, {16{8'h63}});
        end
    endtask

    task automatic test_rounds2();
        logic [3:0] exp_ctrl [7] = '{4'h0, 4'h8, 4'h1, 4'h0, 4'h8, 4'h1, 4'h0};
        logic [3:0] exp_kidx [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd2};
        logic [127:0] exp_op2;
        logic [127:0] x;
        bit seq_ok = 1'b1;
        r2_data_in = rand128();
        x = r2_data_in ^ keys[0];
        for (int r = 1; r <= 2; r++) x = rotl(sub_bytes(x, 1'b0), 32) ^ keys[r];
        @(negedge clk);
        r2_start = 1'b1;
        @(negedge clk);
        r2_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            case (exp_ctrl[i])
                4'h0:    exp_op2 = keys[exp_kidx[i]];
                4'h1:    exp_op2 = 128'd32;
                default: exp_op2 = '0;
            endcase
            if (r2_ctrl !== exp_ctrl[i] || r2_key_idx !== exp_kidx[i] || r2_op2 !== exp_op2) begin
                seq_ok = 1'b0;
                $display("FAIL r2_seq: cycle %0d ctrl=%b kidx=%0d op2=%h want ctrl=%b kidx=%0d op2=%h",
                         i, r2_ctrl, r2_key_idx, r2_op2, exp_ctrl[i], exp_kidx[i], exp_op2);
            end
            @(negedge clk);
        end
        checks++;
        if (!seq_ok) errors++;
        checks++;
        if (r2_done !== 1'b1 || r2_data_out !== x) begin
            errors++;
            $display("FAIL r2_result: done=%b data=%h want done=1 data=%h", r2_done, r2_data_out, x);
        end
    endtask

    task automatic test_enc_dec();
        logic [127:0] pt = 128'h00112233445566778899AABBCCDDEEFF;
        logic [127:0] exp, ct;
        int n;
        bit to;
        sb_q.push_back(enc_ref(pt));
        start_op(1'b0, pt);
        n = 0;
        wait_done(n, to);
        checks++;
        if (to || n != 31) begin
            errors++;
            $display("FAIL enc_latency: got %0d cycles (timeout=%0d) want 31", n, to);
        end
        exp = sb_q.pop_front();
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL enc_data: got %h want %h", data_out, exp);
        end
        ct = data_out;
        sb_q.push_back(pt);
        start_op(1'b1, ct);
        n = 0;
        wait_done(n, to);
        checks++;
        if (to || n != 31) begin
            errors++;
            $display("FAIL dec_latency: got %0d cycles (timeout=%0d) want 31", n, to);
        end
        exp = sb_q.pop_front();
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL dec_data: got %h want %h", data_out, exp);
        end
    endtask

    task automatic test_ignored_start();
        logic [127:0] p = rand128();
        logic [127:0] exp;
        int n;
        int extra = 0;
        bit to;
        sb_q.push_back(enc_ref(p));
        start_op(1'b0, p);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            n++;
        end
        start   = 1'b1;
        mode    = 1'b1;
        data_in = '1;
        @(negedge clk);
        n++;
        start = 1'b0;
        wait_done(n, to);
        checks++;
        if (to || n != 31) begin
            errors++;
            $display("FAIL ign_latency: got %0d cycles (timeout=%0d) want 31", n, to);
        end
        exp = sb_q.pop_front();
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL ign_data: got %h want %h", data_out, exp);
        end
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_extra_done: got %0d extra done pulses busy=%b want 0 and 0", extra, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] p = rand128();
        logic [127:0] exp;
        int n;
        int extra = 0;
        bit to;
        start_op(1'b0, p);
        repeat (12) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done} !== 2'b00 || data_out !== '0) begin
            errors++;
            $display("FAIL rst_async: busy=%b done=%b data_out=%h want 0 0 0", busy, done, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d cycles with busy/done after reset want 0", extra);
        end
        sb_q.push_back(enc_ref(p));
        start_op(1'b0, p);
        n = 0;
        wait_done(n, to);
        checks++;
        if (to || n != 31) begin
            errors++;
            $display("FAIL rst_latency: got %0d cycles (timeout=%0d) want 31", n, to);
        end
        exp = sb_q.pop_front();
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL rst_data: got %h want %h", data_out, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a = rand128();
        logic [127:0] exp, ca;
        int n;
        bit to;
        bit stable = 1'b1;
        sb_q.push_back(enc_ref(a));
        start_op(1'b0, a);
        n = 0;
        wait_done(n, to);
        exp = sb_q.pop_front();
        checks++;
        if (to || data_out !== exp) begin
            errors++;
            $display("FAIL b2b_first: got %h (timeout=%0d) want %h", data_out, to, exp);
        end
        ca = data_out;
        // Start in the done cycle; second op decrypts the first result back to a.
        sb_q.push_back(a);
        start   = 1'b1;
        mode    = 1'b1;
        data_in = ca;
        @(negedge clk);
        start   = 1'b0;
        mode    = 1'b0;
        data_in = '1;
        n = 0;
        while (!done && n < 200) begin
            if (data_out !== ca || busy !== 1'b1) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL b2b_hold: data_out/busy changed before second done, want %h busy=1", ca);
        end
        checks++;
        if (n != 31) begin
            errors++;
            $display("FAIL b2b_latency: got %0d cycles want 31", n);
        end
        exp = sb_q.pop_front();
        checks++;
        if (data_out !== exp) begin
            errors++;
            $display("FAIL b2b_second: got %h want %h", data_out, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) keys[i] = KBASE ^ 128'(i);
        start      = 1'b0;
        mode       = 1'b0;
        data_in    = '0;
        r1_start   = 1'b0;
        r2_start   = 1'b0;
        r2_data_in = '0;
        rst        = 1'b0;
        test_reset();
        test_rounds1();
        test_rounds2();
        test_enc_dec();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
